// File: rtl/systolic_weight_load_ctrl_if.sv
// Weight-buffer stream into the load sequencer: one PE row of weights per beat.
// A beat transfers on a rising edge where i_W_Valid and o_W_Ready are both high; the master holds valid and data stable until then.
interface systolic_weight_load_ctrl_if #(
  parameter int PE_COL = 8,
  parameter int DATA_W = 8
);
  logic                     i_W_Valid;
  logic                     o_W_Ready;
  logic [PE_COL*DATA_W-1:0] i_W_Data;

  modport master (output i_W_Valid, output i_W_Data, input o_W_Ready);
  modport slave  (input i_W_Valid, input i_W_Data, output o_W_Ready);
endinterface

// File: rtl/systolic_weight_load_ctrl.sv
// Weight-load sequencer: pulls rows from the weight buffer and drives the
// registered row-ID / column-enable / data stage in front of the PE array.
module systolic_weight_load_ctrl #(
  parameter int PE_ROW     = 8,
  parameter int PE_COL     = 8,
  parameter int BIT_ROW_ID = 3,
  parameter int DATA_W     = 8,
  parameter int DRAIN_CYC  = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_Start,
  input  logic [BIT_ROW_ID:0]      i_Num_Rows,
  input  logic [PE_COL-1:0]        i_Col_Mask,
  input  logic                     i_Abort,
  systolic_weight_load_ctrl_if.slave w_if,
  output logic [BIT_ROW_ID-1:0]    o_Systolic_En_ID,
  output logic [PE_COL-1:0]        o_Systolic_En_W,
  output logic [PE_COL*DATA_W-1:0] o_Systolic_W_Data,
  output logic                     o_Busy,
  output logic                     o_Done,
  output logic [1:0]               o_Dbg_State
);

  localparam int CW = BIT_ROW_ID + 1;
  localparam int DW = $clog2(DRAIN_CYC + 2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            row_cnt_q, row_cnt_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PE_COL-1:0]        mask_q, mask_d;
  logic [DW-1:0]            drain_cnt_q, drain_cnt_d;
  logic [BIT_ROW_ID-1:0]    en_id_q, en_id_d;
  logic [PE_COL-1:0]        en_w_q, en_w_d;
  logic [PE_COL*DATA_W-1:0] w_data_q, w_data_d;

  logic          w_ready;
  logic          xfer;
  logic [CW-1:0] num_clamped;

  // Ready is the only combinational output so abort can block a beat in the same cycle.
  assign w_ready     = (state_q == S_LOAD) && !i_Abort;
  assign w_if.o_W_Ready = w_ready;
  assign xfer        = w_if.i_W_Valid && w_ready;
  assign num_clamped = (i_Num_Rows > CW'(PE_ROW)) ? CW'(PE_ROW) : i_Num_Rows;

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    drain_cnt_d = drain_cnt_q;
    en_id_d     = en_id_q;
    en_w_d      = '0;
    w_data_d    = w_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_Start && !i_Abort) begin
          mask_d      = i_Col_Mask;
          cnt_d       = num_clamped;
          row_cnt_d   = '0;
          drain_cnt_d = '0;
          state_d     = (num_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (i_Abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          en_id_d   = row_cnt_q[BIT_ROW_ID-1:0];
          en_w_d    = mask_q;
          w_data_d  = w_if.i_W_Data;
          row_cnt_d = row_cnt_q + CW'(1);
          if ((row_cnt_q + CW'(1)) == cnt_q) begin
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (i_Abort) begin
          state_d = S_IDLE;
        end else if (drain_cnt_q == DW'(DRAIN_CYC)) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      drain_cnt_q <= '0;
      en_id_q     <= '0;
      en_w_q      <= '0;
      w_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      drain_cnt_q <= drain_cnt_d;
      en_id_q     <= en_id_d;
      en_w_q      <= en_w_d;
      w_data_q    <= w_data_d;
    end
  end

  assign o_Systolic_En_ID  = en_id_q;
  assign o_Systolic_En_W   = en_w_q;
  assign o_Systolic_W_Data = w_data_q;
  assign o_Busy            = (state_q != S_IDLE);
  assign o_Done            = (state_q == S_DONE);
  assign o_Dbg_State       = state_q;

endmodule

// File: tb/tb_systolic_weight_load_ctrl.sv
// Directed bench for systolic_weight_load_ctrl: basic load, gaps, count
// boundaries, abort, start-while-busy and mid-drain reset.
module tb_systolic_weight_load_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_Start;
  logic [3:0]  i_Num_Rows;
  logic [7:0]  i_Col_Mask;
  logic        i_Abort;
  logic [2:0]  o_Systolic_En_ID;
  logic [7:0]  o_Systolic_En_W;
  logic [63:0] o_Systolic_W_Data;
  logic        o_Busy;
  logic        o_Done;
  logic [1:0]  o_Dbg_State;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_d;

  systolic_weight_load_ctrl_if #(.PE_COL(8), .DATA_W(8)) w_if ();

  systolic_weight_load_ctrl dut (
    .CLK               (CLK),
    .RST               (RST),
    .i_Start           (i_Start),
    .i_Num_Rows        (i_Num_Rows),
    .i_Col_Mask        (i_Col_Mask),
    .i_Abort           (i_Abort),
    .w_if              (w_if),
    .o_Systolic_En_ID  (o_Systolic_En_ID),
    .o_Systolic_En_W   (o_Systolic_En_W),
    .o_Systolic_W_Data (o_Systolic_W_Data),
    .o_Busy            (o_Busy),
    .o_Done            (o_Done),
    .o_Dbg_State       (o_Dbg_State)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   row;

  initial begin
    RST = 1'b0; i_Start = 1'b0; i_Num_Rows = '0; i_Col_Mask = '0; i_Abort = 1'b0;
    w_if.i_W_Valid = 1'b0; w_if.i_W_Data = '0;
    tick(); tick();
    chk("rst_en_w", 64'(o_Systolic_En_W), 64'h0);
    chk("rst_en_id", 64'(o_Systolic_En_ID), 64'h0);
    chk("rst_data", o_Systolic_W_Data, 64'h0);
    chk("rst_busy", 64'(o_Busy), 64'h0);
    chk("rst_done", 64'(o_Done), 64'h0);
    chk("rst_state", 64'(o_Dbg_State), 64'h0);
    RST = 1'b1;
    #1 chk("rst_ready", 64'(w_if.o_W_Ready), 64'h0);

    // Basic load: 4 rows, full mask, valid held high.
    tick();
    i_Start = 1'b1; i_Num_Rows = 4'd4; i_Col_Mask = 8'hFF;
    tick();
    i_Start = 1'b0;
    chk("basic_busy", 64'(o_Busy), 64'h1);
    chk("basic_en_idle", 64'(o_Systolic_En_W), 64'h0);
    w_if.i_W_Valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_if.i_W_Data = rep(8'(8'h11 * (i + 1)));
      exp_q.push_back(w_if.i_W_Data);
      #1 chk("basic_ready", 64'(w_if.o_W_Ready), 64'h1);
      tick();
      exp_d = exp_q.pop_front();
      chk("basic_en_w", 64'(o_Systolic_En_W), 64'hFF);
      chk("basic_en_id", 64'(o_Systolic_En_ID), 64'(i));
      chk("basic_data", o_Systolic_W_Data, exp_d);
    end
    #1 chk("basic_ready_drain", 64'(w_if.o_W_Ready), 64'h0);
    w_if.i_W_Valid = 1'b0;
    tick();
    chk("basic_drain_en", 64'(o_Systolic_En_W), 64'h0);
    chk("basic_drain_done", 64'(o_Done), 64'h0);
    chk("basic_drain_busy", 64'(o_Busy), 64'h1);
    tick();
    chk("basic_done", 64'(o_Done), 64'h1);
    chk("basic_done_busy", 64'(o_Busy), 64'h1);
    tick();
    chk("basic_done_clr", 64'(o_Done), 64'h0);
    chk("basic_idle_busy", 64'(o_Busy), 64'h0);

    // Backpressure gaps: 3 rows, mask 0F.
    i_Start = 1'b1; i_Num_Rows = 4'd3; i_Col_Mask = 8'h0F;
    tick();
    i_Start = 1'b0;
    row = 0;
    for (int k = 0; k < 6; k++) begin
      w_if.i_W_Valid = pat[k];
      w_if.i_W_Data  = rep(8'(8'hA0 + row));
      tick();
      if (pat[k]) begin
        chk("gap_en_w", 64'(o_Systolic_En_W), 64'h0F);
        chk("gap_en_id", 64'(o_Systolic_En_ID), 64'(row));
        chk("gap_data", o_Systolic_W_Data, rep(8'(8'hA0 + row)));
        row++;
      end else begin
        chk("gap_en_w_idle", 64'(o_Systolic_En_W), 64'h0);
      end
    end
    w_if.i_W_Valid = 1'b0;
    tick();
    chk("gap_drain_done", 64'(o_Done), 64'h0);
    tick();
    chk("gap_done", 64'(o_Done), 64'h1);
    tick();
    chk("gap_idle", 64'(o_Busy), 64'h0);

    // Count 0: straight to done, no beats.
    i_Start = 1'b1; i_Num_Rows = 4'd0; i_Col_Mask = 8'hFF; w_if.i_W_Valid = 1'b1;
    tick();
    i_Start = 1'b0;
    chk("zero_done", 64'(o_Done), 64'h1);
    chk("zero_busy", 64'(o_Busy), 64'h1);
    chk("zero_en_w", 64'(o_Systolic_En_W), 64'h0);
    #1 chk("zero_ready", 64'(w_if.o_W_Ready), 64'h0);
    tick();
    chk("zero_done_clr", 64'(o_Done), 64'h0);
    chk("zero_idle", 64'(o_Busy), 64'h0);

    // Count 15 clamps to 8 rows.
    i_Start = 1'b1; i_Num_Rows = 4'd15; i_Col_Mask = 8'h3C;
    tick();
    i_Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_if.i_W_Data = rep(8'(8'h50 + i));
      tick();
      chk("clamp_en_w", 64'(o_Systolic_En_W), 64'h3C);
      chk("clamp_en_id", 64'(o_Systolic_En_ID), 64'(i));
    end
    #1 chk("clamp_ready_drain", 64'(w_if.o_W_Ready), 64'h0);
    w_if.i_W_Valid = 1'b0;
    tick();
    chk("clamp_drain_en", 64'(o_Systolic_En_W), 64'h0);
    tick();
    chk("clamp_done", 64'(o_Done), 64'h1);
    tick();
    chk("clamp_idle", 64'(o_Busy), 64'h0);

    // Abort on the third beat.
    i_Start = 1'b1; i_Num_Rows = 4'd8; i_Col_Mask = 8'hFF;
    tick();
    i_Start = 1'b0; w_if.i_W_Valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w_if.i_W_Data = rep(8'(8'hC0 + i));
      tick();
      chk("abort_en_id", 64'(o_Systolic_En_ID), 64'(i));
      chk("abort_en_w", 64'(o_Systolic_En_W), 64'hFF);
    end
    w_if.i_W_Data = rep(8'hC2); i_Abort = 1'b1;
    #1 chk("abort_ready", 64'(w_if.o_W_Ready), 64'h0);
    tick();
    i_Abort = 1'b0; w_if.i_W_Valid = 1'b0;
    chk("abort_en_w_off", 64'(o_Systolic_En_W), 64'h0);
    chk("abort_busy", 64'(o_Busy), 64'h0);
    chk("abort_done", 64'(o_Done), 64'h0);
    chk("abort_data_hold", o_Systolic_W_Data, rep(8'hC1));
    tick();
    chk("abort_no_done", 64'(o_Done), 64'h0);
    i_Start = 1'b1; i_Num_Rows = 4'd2; i_Col_Mask = 8'h01;
    tick();
    i_Start = 1'b0;
    chk("restart_busy", 64'(o_Busy), 64'h1);
    w_if.i_W_Valid = 1'b1; w_if.i_W_Data = rep(8'hD0);
    tick();
    chk("restart_en_id0", 64'(o_Systolic_En_ID), 64'h0);
    chk("restart_en_w", 64'(o_Systolic_En_W), 64'h01);
    w_if.i_W_Data = rep(8'hD1);
    tick();
    chk("restart_en_id1", 64'(o_Systolic_En_ID), 64'h1);
    w_if.i_W_Valid = 1'b0;
    tick(); tick();
    chk("restart_done", 64'(o_Done), 64'h1);
    tick();

    // Abort beats a simultaneous start in idle.
    i_Start = 1'b1; i_Abort = 1'b1; i_Num_Rows = 4'd2;
    tick();
    i_Start = 1'b0; i_Abort = 1'b0;
    chk("abort_start_busy", 64'(o_Busy), 64'h0);

    // Start while busy is ignored, then reset mid-drain.
    i_Start = 1'b1; i_Num_Rows = 4'd3; i_Col_Mask = 8'hFF;
    tick();
    i_Start = 1'b0; w_if.i_W_Valid = 1'b1; w_if.i_W_Data = rep(8'hE0);
    tick();
    chk("busy_start_id0", 64'(o_Systolic_En_ID), 64'h0);
    i_Start = 1'b1; i_Num_Rows = 4'd1; w_if.i_W_Data = rep(8'hE1);
    tick();
    i_Start = 1'b0;
    chk("busy_start_id1", 64'(o_Systolic_En_ID), 64'h1);
    chk("busy_start_en_w", 64'(o_Systolic_En_W), 64'hFF);
    w_if.i_W_Data = rep(8'hE2);
    #1 chk("busy_start_ready", 64'(w_if.o_W_Ready), 64'h1);
    tick();
    chk("busy_start_id2", 64'(o_Systolic_En_ID), 64'h2);
    #1 chk("busy_start_drain_ready", 64'(w_if.o_W_Ready), 64'h0);
    w_if.i_W_Valid = 1'b0;
    tick();
    chk("busy_start_drain", 64'(o_Busy), 64'h1);
    RST = 1'b0;
    tick();
    chk("midrst_en_w", 64'(o_Systolic_En_W), 64'h0);
    chk("midrst_en_id", 64'(o_Systolic_En_ID), 64'h0);
    chk("midrst_data", o_Systolic_W_Data, 64'h0);
    chk("midrst_busy", 64'(o_Busy), 64'h0);
    chk("midrst_done", 64'(o_Done), 64'h0);
    RST = 1'b1;
    tick();
    chk("midrst_no_done", 64'(o_Done), 64'h0);
    chk("midrst_idle", 64'(o_Busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
